core_lsq_issue: RTL

//  Load/store issue stage upstream of the memory access unit (MAU). Accepts

---
 rtl/core_lsq_issue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/core_lsq_issue.sv
// core_lsq_issue: load/store issue stage with address generation, alignment check, request FIFO and MAU dispatch.
module core_lsq_issue #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [1:0]      ex_op,
    input  logic [AW-1:0]   ex_base,
    input  logic [15:0]     ex_offset,
    input  logic [DW-1:0]   ex_sdata,
    input  logic [TAGW-1:0] ex_rd,
    input  logic            flush,
    output logic            mau_dis,
    output logic            mau_flush,
    output logic [1:0]      mau_op,
    output logic [AW-1:0]   mau_addr,
    output logic [DW-1:0]   datain,
    input  logic [DW-1:0]   data_out,
    input  logic            busy,
    output logic            wb_valid,
    output logic [TAGW-1:0] wb_rd,
    output logic [DW-1:0]   wb_data,
    output logic            exc_misalign,
    output logic [AW-1:0]   exc_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    logic [1:0]      q_op   [DEPTH];
    logic [AW-1:0]   q_addr [DEPTH];
    logic [DW-1:0]   q_data [DEPTH];
    logic [TAGW-1:0] q_rd   [DEPTH];
    logic [PW-1:0]   wp, rp;
    logic [PW:0]     count;
    logic            inflight, busy_q;
    logic [1:0]      lat_op, lat_lo;
    logic [TAGW-1:0] lat_rd;
    logic [AW-1:0]   addr;
    logic            accept, mis, push, pop, done;

    assign ex_ready = count != FULL;
    assign addr     = ex_base + {{(AW-16){ex_offset[15]}}, ex_offset};
    assign accept   = ex_valid & ex_ready & !flush;
    assign mis      = !ex_op[0] & (addr[1:0] != 2'b00);
    assign push     = accept & !mis;
    assign pop      = (count != '0) & !busy & !inflight & !flush;
    assign done     = busy_q & !busy & inflight;

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wp]   <= ex_op;
            q_addr[wp] <= addr;
            q_data[wp] <= (ex_op == 2'b11) ? {(DW/8){ex_sdata[7:0]}} : ex_sdata;
            q_rd[wp]   <= ex_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            inflight     <= 1'b0;
            busy_q       <= 1'b0;
            lat_op       <= '0;
            lat_lo       <= '0;
            lat_rd       <= '0;
            mau_dis      <= 1'b0;
            mau_flush    <= 1'b0;
            mau_op       <= '0;
            mau_addr     <= '0;
            datain       <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            exc_misalign <= 1'b0;
            exc_addr     <= '0;
        end else begin
            mau_dis      <= pop;
            mau_flush    <= flush & inflight;
            wb_valid     <= done & !flush & !lat_op[1];
            exc_misalign <= accept & mis;
            busy_q       <= busy;
            if (accept & mis)
                exc_addr <= addr;
            if (flush) begin
                wp       <= '0;
                rp       <= '0;
                count    <= '0;
                inflight <= 1'b0;
            end else begin
                if (push)
                    wp <= wp + 1'b1;
                if (pop)
                    rp <= rp + 1'b1;
                count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
                if (pop) begin
                    inflight <= 1'b1;
                    lat_op   <= q_op[rp];
                    lat_rd   <= q_rd[rp];
                    lat_lo   <= q_addr[rp][1:0];
                    mau_op   <= q_op[rp];
                    mau_addr <= q_addr[rp];
                    datain   <= q_data[rp];
                end else if (done) begin
                    inflight <= 1'b0;
                end
                // LB returns the addressed little-endian byte, zero-extended
                if (done & !lat_op[1]) begin
                    wb_rd   <= lat_rd;
                    wb_data <= lat_op[0] ? {{(DW-8){1'b0}}, data_out[{lat_lo, 3'b000} +: 8]} : data_out;
                end
            end
        end
    end
endmodule
